dcache_direct: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store port and ExternalMemory.
- Hides external-memory latency on read hits.
- Upstream side: CPU request port with a stall output.
- Downstream side: drives ExternalMemory's `mem_addr` / `mem_read_en` / `mem_write_en` / `mem_write_val` and consumes its `mem_read_val`.

---
 rtl/dcache_direct.sv | 151 +++++++++++++++
 tb/tb_dcache_direct.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of ExternalMemory.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_direct #(
   parameter int MEM_WIDTH   = 32,
   parameter int MEM_SIZE    = 256,
   parameter int CACHE_LINES = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(MEM_SIZE)-1:0]  cpu_addr,
   input  logic                         cpu_read_en,
   input  logic                         cpu_write_en,
   input  logic [MEM_WIDTH-1:0]         cpu_write_val,
   output logic [MEM_WIDTH-1:0]         cpu_read_val,
   output logic                         cpu_stall,
   output logic [$clog2(MEM_SIZE)-1:0]  mem_addr,
   output logic                         mem_read_en,
   output logic                         mem_write_en,
   output logic [MEM_WIDTH-1:0]         mem_write_val,
   input  logic [MEM_WIDTH-1:0]         mem_read_val
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]                  hit_count,
   output logic [31:0]                  miss_count
`endif
);

   // state | meaning
   // IDLE  | serve read hits, detect misses and stores
   // FILL  | external read of the missed word, line written on last cycle
   // WRITE | external write-through of the store

   localparam int AW = $clog2(MEM_SIZE);
   localparam int IW = $clog2(CACHE_LINES);
   localparam int TW = AW - IW;
   localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t                 state, state_nxt;
   logic [LW-1:0]          lat_cnt;
   logic                   wr_done;
   logic [CACHE_LINES-1:0] valid;
   logic [TW-1:0]          tag_arr  [CACHE_LINES];
   logic [MEM_WIDTH-1:0]   data_arr [CACHE_LINES];

   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic [IW-1:0] fill_idx;
   logic [TW-1:0] fill_tag;
   logic          line_match;
   logic          read_req;
   logic          write_req;
   logic          lat_last;

   assign idx        = cpu_addr[IW-1:0];
   assign tag        = cpu_addr[AW-1:IW];
   assign fill_idx   = mem_addr[IW-1:0];
   assign fill_tag   = mem_addr[AW-1:IW];
   assign line_match = valid[idx] && (tag_arr[idx] == tag);
   assign read_req   = cpu_read_en && !cpu_write_en;
   // The held store is released for exactly one IDLE cycle after its WRITE completes.
   assign write_req  = cpu_write_en && !wr_done;
   assign lat_last   = (lat_cnt == LW'(MEM_LATENCY - 1));

   always_comb begin
      state_nxt    = state;
      cpu_stall    = 1'b0;
      cpu_read_val = '0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      case (state)
         IDLE: begin
            if (write_req) begin
               cpu_stall = 1'b1;
               state_nxt = WRITE;
            end else if (read_req && !line_match) begin
               cpu_stall = 1'b1;
               state_nxt = FILL;
            end else if (read_req) begin
               cpu_read_val = data_arr[idx];
            end
         end
         FILL: begin
            cpu_stall   = 1'b1;
            mem_read_en = 1'b1;
            if (lat_last) state_nxt = IDLE;
         end
         WRITE: begin
            cpu_stall    = 1'b1;
            mem_write_en = 1'b1;
            if (lat_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         lat_cnt       <= '0;
         wr_done       <= 1'b0;
         valid         <= '0;
         mem_addr      <= '0;
         mem_write_val <= '0;
      end else begin
         state   <= state_nxt;
         wr_done <= (state == WRITE) && lat_last;
         if (state == IDLE) begin
            lat_cnt <= '0;
            if (state_nxt != IDLE) mem_addr <= cpu_addr;
            if (state_nxt == WRITE) mem_write_val <= cpu_write_val;
         end else if (lat_last) begin
            lat_cnt       <= '0;
            mem_addr      <= '0;
            mem_write_val <= '0;
            if (state == FILL) valid[fill_idx] <= 1'b1;
         end else begin
            lat_cnt <= lat_cnt + LW'(1);
         end
      end
   end

   // Payload arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == IDLE && write_req && line_match)
            data_arr[idx] <= cpu_write_val;
         if (state == FILL && lat_last) begin
            data_arr[fill_idx] <= mem_read_val;
            tag_arr[fill_idx]  <= fill_tag;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state == IDLE && !write_req && read_req && line_match && hit_count != '1)
            hit_count <= hit_count + 32'd1;
         if (state == IDLE && state_nxt == FILL && miss_count != '1)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Directed self-checking bench for dcache_direct with a behavioural ExternalMemory model.
module tb_dcache_direct;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cpu_addr;
   logic        cpu_read_en;
   logic        cpu_write_en;
   logic [31:0] cpu_write_val;
   logic [31:0] cpu_read_val;
   logic        cpu_stall;
   logic [7:0]  mem_addr;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_write_val;
   logic [31:0] mem_read_val;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];
   logic        load_en = 1'b0;
   logic [7:0]  load_addr = '0;
   logic [31:0] load_val = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_val;
      else if (mem_write_en) mem[mem_addr] <= mem_write_val;
   end
   assign mem_read_val = mem_read_en ? mem[mem_addr] : 32'h0;

   dcache_direct #(
      .MEM_WIDTH(32), .MEM_SIZE(256), .CACHE_LINES(16), .MEM_LATENCY(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr(cpu_addr), .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
      .cpu_write_val(cpu_write_val), .cpu_read_val(cpu_read_val), .cpu_stall(cpu_stall),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_write_val(mem_write_val), .mem_read_val(mem_read_val)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   task automatic load_word(input logic [7:0] a, input logic [31:0] v);
      load_addr = a; load_val = v; load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Issues a held load; counts stalled cycles and external read cycles.
   task automatic do_read(input logic [7:0] a, input logic [31:0] exp_val,
                          input int exp_stall, input string name);
      int stalls = 0;
      int rds = 0;
      bit bad = 0;
      cpu_addr = a; cpu_read_en = 1'b1; cpu_write_en = 1'b0;
      #1;
      while (cpu_stall && stalls < 20) begin
         stalls++;
         if (mem_read_en) begin
            rds++;
            if (mem_addr !== a) bad = 1;
         end
         if (mem_write_en) bad = 1;
         @(negedge clk); #1;
      end
      checks++;
      if (stalls != exp_stall) begin
         errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_stall);
      end
      checks++;
      if (rds != ((exp_stall == 0) ? 0 : exp_stall - 1)) begin
         errors++; $display("FAIL %s mem_read_cycles got %0d want %0d", name, rds,
                            (exp_stall == 0) ? 0 : exp_stall - 1);
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL %s mem_bus got bad_addr_or_write want addr %0d read-only", name, a);
      end
      checks++;
      if (cpu_read_val !== exp_val) begin
         errors++; $display("FAIL %s read_val got %h want %h", name, cpu_read_val, exp_val);
      end
      @(negedge clk);
      cpu_read_en = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] v, input string name);
      int stalls = 0;
      int wrs = 0;
      bit bad = 0;
      cpu_addr = a; cpu_write_val = v; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
      #1;
      while (cpu_stall && stalls < 20) begin
         stalls++;
         if (mem_write_en) begin
            wrs++;
            if (mem_addr !== a || mem_write_val !== v) bad = 1;
         end
         if (mem_read_en) bad = 1;
         @(negedge clk); #1;
      end
      checks++;
      if (stalls != 3) begin
         errors++; $display("FAIL %s stall_cycles got %0d want 3", name, stalls);
      end
      checks++;
      if (wrs != 2) begin
         errors++; $display("FAIL %s mem_write_cycles got %0d want 2", name, wrs);
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL %s mem_bus got bad_addr_data_or_read want %0d/%h", name, a, v);
      end
      checks++;
      if (mem[a] !== v) begin
         errors++; $display("FAIL %s memory got %h want %h", name, mem[a], v);
      end
      @(negedge clk);
      cpu_write_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cpu_addr = '0; cpu_read_en = 1'b0; cpu_write_en = 1'b0; cpu_write_val = '0;
      @(negedge clk);
      load_word(8'd212, 32'h0000_1825);
      load_word(8'd4,   32'h0000_0001);
      load_word(8'd20,  32'h0000_0000);
      load_word(8'd8,   32'h0000_0001);
      load_word(8'd30,  32'h0000_0077);
      load_word(8'd100, 32'h0000_0064);
      rst_n = 1'b1;
      #1;
      checks++;
      if (cpu_stall !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl got stall=%b rd=%b wr=%b want 0 0 0",
                            cpu_stall, mem_read_en, mem_write_en);
      end
      checks++;
      if (mem_addr !== 8'd0 || mem_write_val !== 32'd0 || cpu_read_val !== 32'd0) begin
         errors++; $display("FAIL reset_data got addr=%h wval=%h rval=%h want 0 0 0",
                            mem_addr, mem_write_val, cpu_read_val);
      end
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++; $display("FAIL reset_stats got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_read_miss_hit();
      do_read(8'd212, 32'h0000_1825, 3, "cold_read_212");
      do_read(8'd212, 32'h0000_1825, 0, "hit_read_212");
   endtask

   task automatic test_conflict();
      do_read(8'd4,  32'h0000_0001, 3, "conflict_4a");
      do_read(8'd20, 32'h0000_0000, 3, "conflict_20");
      do_read(8'd4,  32'h0000_0001, 3, "conflict_4b");
   endtask

   task automatic test_write_hit();
      do_read(8'd8, 32'h0000_0001, 3, "pre_read_8");
      do_write(8'd8, 32'hDEAD_BEEF, "write_hit_8");
      do_read(8'd8, 32'hDEAD_BEEF, 0, "post_read_8");
   endtask

   task automatic test_write_miss();
      do_write(8'd30, 32'h0000_0005, "write_miss_30");
      do_read(8'd30, 32'h0000_0005, 3, "post_read_30");
   endtask

   task automatic test_reset_mid_fill();
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_count !== 32'd8 || miss_count !== 32'd6) begin
         errors++; $display("FAIL stats_before got hit=%0d miss=%0d want 8 6", hit_count, miss_count);
      end
`endif
      cpu_addr = 8'd100; cpu_read_en = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_read_en !== 1'b1 || mem_addr !== 8'd100) begin
         errors++; $display("FAIL mid_fill got rd=%b addr=%0d want 1 100", mem_read_en, mem_addr);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || mem_addr !== 8'd0 || cpu_read_val !== 32'd0) begin
         errors++; $display("FAIL abort_fill got rd=%b wr=%b addr=%0d rval=%h want 0 0 0 0",
                            mem_read_en, mem_write_en, mem_addr, cpu_read_val);
      end
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++; $display("FAIL stats_after_reset got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
      end
`endif
      @(negedge clk);
      cpu_read_en = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      do_read(8'd100, 32'h0000_0064, 3, "reread_100");
      do_read(8'd8, 32'hDEAD_BEEF, 3, "reread_8_invalidated");
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_conflict();
      test_write_hit();
      test_write_miss();
      test_reset_mid_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
